// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - parametrised sequential UART receive deframer with valid/ack holding register
module uart_rx_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_bit,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int              CW        = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]   LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic            PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CW-1:0]           r_cnt;
    logic                    r_pbit;
    logic                    r_perr;
    logic                    r_ferr;

    logic                    w_commit;
    logic                    w_ferr_final;
    logic                    w_par_exp;
    logic                    w_ack;

    // The final stop strobe commits; its own bit still counts towards the frame error
    assign w_commit     = (r_state == S_STOP) && bit_valid && (r_cnt == LAST_STOP);
    assign w_ferr_final = r_ferr | ~bit_in;
    assign w_par_exp    = (^r_shift) ^ PAR_ODD;
    assign w_ack        = data_valid & data_ack;

    // Frame assembly FSM plus the valid/ack holding register, all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pbit      <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            data_out    <= '0;
            parity_bit  <= 1'b0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (bit_valid) begin
                case (r_state)
                    S_IDLE: begin
                        // A 1 is idle line; a 0 is the start bit
                        if (!bit_in) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_pbit  <= 1'b0;
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {bit_in, r_shift[DATA_WIDTH-1:1]};
                        if (r_cnt == LAST_DATA) begin
                            r_cnt   <= '0;
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        r_pbit  <= bit_in;
                        r_perr  <= (bit_in != w_par_exp);
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // A 0 here is a framing error or break, never a new start bit
                        if (!bit_in) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_cnt == LAST_STOP) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end

            if (w_commit) begin
                data_out    <= r_shift;
                parity_bit  <= r_pbit;
                parity_err  <= r_perr;
                frame_err   <= w_ferr_final;
                data_valid  <= 1'b1;
                overrun_err <= data_valid & ~data_ack;
            end else if (w_ack) begin
                data_valid  <= 1'b0;
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - scoreboard bench for uart_rx_deframer in 8E1, 7O2 and 8N1 builds
module tb_uart_rx_deframer;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pbit;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] bv;
    logic [2:0] bi;
    logic [2:0] ack;

    logic [7:0] do0;
    logic [6:0] do1;
    logic [7:0] do2;
    logic [2:0] pb_o;
    logic [2:0] dv_o;
    logic [2:0] pe_o;
    logic [2:0] fe_o;
    logic [2:0] ov_o;
    logic [2:0] bz_o;
    logic [8:0] od [3];

    exp_t sb[$];
    logic m_valid [3];
    int   checks;
    int   errors;

    uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .bit_valid(bv[0]), .bit_in(bi[0]), .data_ack(ack[0]),
        .data_out(do0), .parity_bit(pb_o[0]), .data_valid(dv_o[0]), .parity_err(pe_o[0]),
        .frame_err(fe_o[0]), .overrun_err(ov_o[0]), .busy(bz_o[0])
    );

    uart_rx_deframer #(.DATA_WIDTH(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .bit_valid(bv[1]), .bit_in(bi[1]), .data_ack(ack[1]),
        .data_out(do1), .parity_bit(pb_o[1]), .data_valid(dv_o[1]), .parity_err(pe_o[1]),
        .frame_err(fe_o[1]), .overrun_err(ov_o[1]), .busy(bz_o[1])
    );

    uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .bit_valid(bv[2]), .bit_in(bi[2]), .data_ack(ack[2]),
        .data_out(do2), .parity_bit(pb_o[2]), .data_valid(dv_o[2]), .parity_err(pe_o[2]),
        .frame_err(fe_o[2]), .overrun_err(ov_o[2]), .busy(bz_o[2])
    );

    always_comb begin
        od[0] = {1'b0, do0};
        od[1] = {2'b0, do1};
        od[2] = {1'b0, do2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input int s, input logic b, input int gap, input logic a);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bv[s] = 1'b0;
            bi[s] = ~bi[s];
        end
        @(negedge clk);
        bv[s]  = 1'b1;
        bi[s]  = b;
        ack[s] = a;
        @(negedge clk);
        bv[s]  = 1'b0;
        ack[s] = 1'b0;
    endtask

    task automatic send_frame(input int s, input logic [8:0] d, input int dw, input logic pen,
                              input logic pb, input logic odd, input logic [1:0] st, input int nst,
                              input int gap, input logic ack_last);
        exp_t e;
        logic x;
        x = 1'b0;
        for (int i = 0; i < dw; i++) x = x ^ d[i];
        e.sel  = s;
        e.data = d;
        e.pbit = pen ? pb : 1'b0;
        e.perr = pen && (pb != (x ^ odd));
        e.ferr = (st[0] == 1'b0) || (nst == 2 && st[1] == 1'b0);
        e.ovr  = m_valid[s] && !ack_last;
        sb.push_back(e);
        send_bit(s, 1'b0, gap, 1'b0);
        for (int i = 0; i < dw; i++) send_bit(s, d[i], gap, 1'b0);
        if (pen) send_bit(s, pb, gap, 1'b0);
        for (int i = 0; i < nst; i++) send_bit(s, st[i], gap, (i == nst - 1) ? ack_last : 1'b0);
        m_valid[s] = 1'b1;
    endtask

    task automatic check_word(input int s, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".sel"},   9'(s),        9'(e.sel));
            check({tag, ".valid"}, 9'(dv_o[s]),  9'd1);
            check({tag, ".busy"},  9'(bz_o[s]),  9'd0);
            check({tag, ".data"},  od[s],        e.data);
            check({tag, ".pbit"},  9'(pb_o[s]),  9'(e.pbit));
            check({tag, ".perr"},  9'(pe_o[s]),  9'(e.perr));
            check({tag, ".ferr"},  9'(fe_o[s]),  9'(e.ferr));
            check({tag, ".ovr"},   9'(ov_o[s]),  9'(e.ovr));
        end
    endtask

    task automatic ack_word(input int s, input string tag, input logic [8:0] keep);
        @(negedge clk);
        ack[s] = 1'b1;
        @(negedge clk);
        ack[s] = 1'b0;
        m_valid[s] = 1'b0;
        check({tag, ".ack_valid"}, 9'(dv_o[s]), 9'd0);
        check({tag, ".ack_perr"},  9'(pe_o[s]), 9'd0);
        check({tag, ".ack_ferr"},  9'(fe_o[s]), 9'd0);
        check({tag, ".ack_ovr"},   9'(ov_o[s]), 9'd0);
        check({tag, ".ack_data"},  od[s],       keep);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bv  = '0;
        bi  = '1;
        ack = '0;
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;

        do_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d.valid", i), 9'(dv_o[i]), 9'd0);
            check($sformatf("reset%0d.busy", i),  9'(bz_o[i]), 9'd0);
            check($sformatf("reset%0d.data", i),  od[i],       9'd0);
            check($sformatf("reset%0d.flags", i), 9'({pb_o[i], pe_o[i], fe_o[i], ov_o[i]}), 9'd0);
        end

        // 8E1: idle 1s, then 0xA5 with correct parity
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 0, 1'b0);
        check("idle.valid", 9'(dv_o[0]), 9'd0);
        check("idle.busy",  9'(bz_o[0]), 9'd0);
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(0, "a5");
        ack_word(0, "a5", 9'h0A5);

        // 8E1: 0x5A with wrong parity bit, left unacked for the reset test
        send_frame(0, 9'h05A, 8, 1'b1, 1'b1, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(0, "5a");

        // 7O2: 0x3C, good odd parity, second stop bit 0
        send_frame(1, 9'h03C, 7, 1'b1, 1'b1, 1'b1, 2'b01, 2, 0, 1'b0);
        check_word(1, "3c");
        send_bit(1, 1'b1, 0, 1'b0);
        check("3c.after_busy",  9'(bz_o[1]), 9'd0);
        check("3c.after_valid", 9'(dv_o[1]), 9'd1);
        ack_word(1, "3c", 9'h03C);

        // 8N1: back-to-back without ack, then with ack on the second commit
        send_frame(2, 9'h011, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(2, "n11a");
        send_frame(2, 9'h022, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(2, "n22ovr");
        ack_word(2, "n22ovr", 9'h022);
        send_frame(2, 9'h011, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(2, "n11b");
        send_frame(2, 9'h022, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1, 0, 1'b1);
        check_word(2, "n22ack");
        ack_word(2, "n22ack", 9'h022);

        // 8E1: reset after 4 data bits of a partial frame
        send_bit(0, 1'b0, 0, 1'b0);
        send_bit(0, 1'b1, 0, 1'b0);
        send_bit(0, 1'b1, 0, 1'b0);
        send_bit(0, 1'b0, 0, 1'b0);
        send_bit(0, 1'b1, 0, 1'b0);
        check("partial.busy", 9'(bz_o[0]), 9'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
        check("rst_mid.busy",  9'(bz_o[0]), 9'd0);
        check("rst_mid.valid", 9'(dv_o[0]), 9'd0);
        check("rst_mid.data",  od[0],       9'd0);
        send_frame(0, 9'h0C3, 8, 1'b1, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(0, "c3");
        ack_word(0, "c3", 9'h0C3);

        // 8E1: 0x96 uninterrupted, then with 20-cycle gaps and a toggling line
        send_frame(0, 9'h096, 8, 1'b1, 1'b0, 1'b0, 2'b11, 1, 0, 1'b0);
        check_word(0, "96");
        ack_word(0, "96", 9'h096);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 3, 1'b0);
        check("gap_idle.valid", 9'(dv_o[0]), 9'd0);
        check("gap_idle.busy",  9'(bz_o[0]), 9'd0);
        bi[0] = 1'b1;
        send_frame(0, 9'h096, 8, 1'b1, 1'b0, 1'b0, 2'b11, 1, 20, 1'b0);
        check_word(0, "96gap");
        ack_word(0, "96gap", 9'h096);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Parametrised sequential successor to the fixed 11-bit combinational deframe block. It consumes the sampled serial bit stream one bit per bit_valid strobe and assembles the frame: start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, and 1 or 2 stop bits. It checks the frame, then presents the data word with error flags through a valid/ack holding register. It sits in the receiver between the bit sampler and the RX FIFO/host interface.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
bit_valid  in  1  one-cycle strobe; bit_in is a sampled line bit this cycle.
bit_in  in  1  sampled RX line value.
data_ack  in  1  consumer accepts the presented word.
data_out  out  DATA_WIDTH  received data word.
parity_bit  out  1  received parity bit; 0 when PARITY_EN=0.
data_valid  out  1  word and flags are valid; held until acked.
parity_err  out  1  parity mismatch for the presented word.
frame_err  out  1  at least one stop bit was sampled as 0.
overrun_err  out  1  the previous unacked word was overwritten by this one.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register and bit counter cleared. Reset wins over every other input in the same cycle, including mid-frame. A partial frame is discarded.
- State advances only on cycles with bit_valid=1; otherwise all state holds.
- IDLE: bit_valid with bit_in=1 is ignored (idle line). bit_valid with bit_in=0 is a start bit: go to DATA, counter=0.
- DATA: each bit_valid shifts bit_in into the word LSB-first and increments the counter. On bit DATA_WIDTH go to PARITY if PARITY_EN=1, else STOP.
- PARITY: capture bit_in. Expected parity bit = XOR(data) ^ PARITY_ODD. A mismatch sets the internal perr. Go to STOP.
- STOP: capture STOP_BITS bits. Any 0 sets the internal ferr. There is no early exit on a 0. After the final stop bit, commit and return to IDLE. A 0 stop bit (break) is never reinterpreted as a start bit.
- Commit latency: data_valid, data_out, parity_bit, parity_err and frame_err update on the clock edge after the cycle carrying the final stop bit_valid. The frame is delivered even when errors are flagged.
- Holding register: the outputs stay stable while data_valid=1 and data_ack=0. data_ack while data_valid=1 clears data_valid and all three err flags on the next edge; data_out and parity_bit retain their last value. data_ack while data_valid=0 is ignored.
- Overrun: a commit while data_valid=1 and data_ack=0 overwrites the register and sets overrun_err=1 with the new word.
- Commit and data_ack in the same cycle: the new word loads, data_valid stays 1, and overrun_err=0.
- Counter width is $clog2(DATA_WIDTH+1). The data shift register is exactly DATA_WIDTH bits wide.
- busy=1 from the start-bit cycle's edge until the commit edge.

Test Plan:
- 8E1, idle 1s, then start, 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 1 -> one cycle after the stop strobe: data_out=0xA5, data_valid=1, all err flags 0. Ack -> data_valid=0 next edge.
- 8E1, 0x5A with parity bit 1 -> data_out=0x5A, parity_bit=1, parity_err=1, frame_err=0.
- DATA_WIDTH=7, PARITY_ODD=1, STOP_BITS=2: 0x3C, parity 1, stops 1,0 -> data_out=0x3C, parity_err=0, frame_err=1. The following bit_valid with bit_in=1 keeps the block in IDLE.
- Two back-to-back 8N1 frames 0x11 then 0x22 with no ack -> second word 0x22 shows overrun_err=1. Repeat with ack coinciding with the second commit -> 0x22 shows overrun_err=0 and data_valid stays 1.
- Assert rst after 4 data bits -> busy=0 and data_valid=0 next edge. A fresh full 0xC3 frame is then received correctly, with no trace of the partial frame.
- bit_valid held low for 20 cycles between data bits, with bit_in toggling -> result identical to the uninterrupted frame. Idle 1s before the start bit produce no output.
